control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters SHALL be:
- IW, 32, instruction word width.
- CW, 33, control-word width.
- CNTW, 16, retired-instruction counter width.

REQ-002 Ports SHALL be, in this order:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- I_in  in  IW  instruction word from instruction memory.
- imem_ready  in  1  I_in valid this cycle.
- cw_decoded  in  CW  control word from the instruction-word decoders; combinational from I and state.
- halt_req  in  1  request to stop at the next instruction boundary.
- I  out  IW  instruction register, feeds the decoders.
- state  out  2  current sequencer state, feeds the decoders.
- cw_out  out  CW  control word driven to the datapath.
- imem_req  out  1  fetch request.
- halted  out  1  sequencer is stopped.
- retired_count  out  CNTW  instructions completed.

REQ-003 The cw bit map SHALL be the following, from MSB to LSB:
- [32] ALU databus enable
- [31] ALU B select
- [30:26] ALU function
- [25] regfile B databus enable
- [24:20] select A
- [19:15] select B
- [14:10] write address
- [9] regfile write
- [8] RAM databus enable
- [7] RAM write
- [6] PC databus enable
- [5:4] PC function
- [3] PC input select
- [2] status load
- [1:0] next_state

Function
REQ-004 The states SHALL be encoded as FETCH=0, EX1=1, EX2=2, EX3=3, plus a separate HALT flag; state SHALL equal 0 while halted.

REQ-005 In FETCH with halted=0, imem_req SHALL be 1.

REQ-006 In FETCH with halted=0 and imem_ready=0:
- cw_out SHALL be all zeros.
- state SHALL hold.

REQ-007 In FETCH with halted=0 and imem_ready=1:
- cw_out SHALL be zero except PC function=2'b01 (increment).
- I SHALL load I_in at the clock edge.
- state SHALL become EX1 at the clock edge.
- Fetch-to-EX1 latency SHALL be exactly 1 cycle after imem_ready.

REQ-008 In EX1..EX3, cw_out SHALL equal cw_decoded, and imem_req SHALL be 0.

REQ-009 In EX1..EX3, state SHALL load cw_decoded[1:0] at each edge; I SHALL hold.

REQ-010 When cw_decoded[1:0]=0 in an EX state, the instruction SHALL retire: retired_count SHALL increment by 1 at that edge and state SHALL return to FETCH.

REQ-011 retired_count SHALL wrap modulo 2^CNTW with no saturation or flag.

REQ-012 A next_state value that moves backward (for example EX3 to EX1) SHALL be legal and followed as given; the sequencer SHALL apply no loop limit.

REQ-013 halt_req SHALL be sampled only in FETCH. If halt_req=1 in FETCH, halted SHALL set at the edge, and no fetch SHALL be accepted that cycle even if imem_ready=1.

REQ-014 halt_req asserted during EX states SHALL be ignored until the next FETCH; the instruction in flight SHALL complete.

REQ-015 While halted=1:
- imem_req SHALL be 0.
- cw_out SHALL be all zeros.
- I and retired_count SHALL hold.

REQ-016 halted SHALL clear at the first edge where halt_req=0; the following cycle SHALL be FETCH.

REQ-017 All state SHALL be held in flops; cw_out and imem_req SHALL be combinational from state, halted, imem_ready and cw_decoded only.

Reset
REQ-018 When reset=0, asynchronously and independent of clock:
- state SHALL be FETCH.
- I SHALL be 0.
- halted SHALL be 0.
- retired_count SHALL be 0.

REQ-019 While reset=0, cw_out SHALL be all zeros and imem_req SHALL be 0.

REQ-020 Reset asserted mid-instruction SHALL abandon that instruction with no retire count.

REQ-021 The first cycle after reset release SHALL be FETCH with imem_req=1.

Verification
REQ-022 Fetch then single-step: I_in=0xF2800041, imem_ready=1, then cw_decoded[1:0]=0 in EX1 -> I=0xF2800041 one cycle later; retired_count=1 after 2 cycles; state back to 0.

REQ-023 Three-cycle instruction: cw_decoded next_state sequence 2, 3, 0 -> state sequence 0,1,2,3,0; cw_out equals cw_decoded in EX cycles; retired_count +1 only at the final edge.

REQ-024 Memory wait: imem_ready=0 for 4 cycles in FETCH -> state=0, imem_req=1 and cw_out=0 throughout; I unchanged.

REQ-025 Halt: halt_req=1 during EX2 -> the instruction retires; then halted=1 with imem_req=0 even with imem_ready=1; halt_req=0 -> FETCH resumes the next cycle.

REQ-026 Wrap and reset: preload by retiring 65535 instructions, then one more -> retired_count=0x0000; reset=0 asserted mid-EX2 -> all outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Purpose:
//   Instruction sequencer for a microcoded datapath. In FETCH it requests an
//   instruction word, latches it into I and moves to EX1. In EX1..EX3 the
//   external decoders look at I and state and return a control word. That
//   control word is forwarded to the datapath. Its low two bits select the
//   next execute state. A next_state of 0 retires the instruction and returns
//   to FETCH. A halt request is honoured only at instruction boundaries.
//
// Parameters:
//   IW   - instruction word width
//   CW   - control word width
//   CNTW - retired-instruction counter width
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   I_in          in   instruction word from instruction memory
//   imem_ready    in   I_in is valid this cycle
//   cw_decoded    in   control word from the decoders (combinational from I, state)
//   halt_req      in   request to stop at the next instruction boundary
//   I             out  instruction register, feeds the decoders
//   state         out  current sequencer state, feeds the decoders
//   cw_out        out  control word driven to the datapath
//   imem_req      out  fetch request
//   halted        out  sequencer is stopped
//   retired_count out  number of instructions completed (wraps)
//
// Control word layout (MSB to LSB):
//   [32] ALU databus enable    [31] ALU B select         [30:26] ALU function
//   [25] regfile B databus en  [24:20] select A          [19:15] select B
//   [14:10] write address      [9] regfile write         [8] RAM databus enable
//   [7] RAM write              [6] PC databus enable     [5:4] PC function
//   [3] PC input select        [2] status load           [1:0] next_state
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int IW   = 32,
  parameter int CW   = 33,
  parameter int CNTW = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IW-1:0]   I_in,
  input  logic            imem_ready,
  input  logic [CW-1:0]   cw_decoded,
  input  logic            halt_req,
  output logic [IW-1:0]   I,
  output logic [1:0]      state,
  output logic [CW-1:0]   cw_out,
  output logic            imem_req,
  output logic            halted,
  output logic [CNTW-1:0] retired_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EX1   = 2'd1,
    EX2   = 2'd2,
    EX3   = 2'd3
  } seq_state_t;

  localparam int          PC_FUNC_LSB = 4;
  localparam logic [1:0]  PC_INC      = 2'b01;

  seq_state_t    cur_state;
  logic [CW-1:0] fetch_cw;
  logic [1:0]    next_sel;
  logic          retire;

  assign state = cur_state;

  // The fetch-cycle control word only advances the PC; every other
  // datapath action stays idle while the instruction word is latched.
  always_comb begin
    fetch_cw = '0;
    fetch_cw[PC_FUNC_LSB +: 2] = PC_INC;
  end

  // The decoder picks the next execute step. A zero means "done", which
  // also lands us back in FETCH because FETCH is encoded as 0.
  assign next_sel = cw_decoded[1:0];
  assign retire   = (next_sel == 2'b00);

  // Sequencer state, instruction register, halt flag and retire counter.
  // While halted, state is parked in FETCH and only halt_req is watched.
  // The edge that clears halted does not also accept a fetch.
  // halt_req is only looked at on a FETCH boundary, so an instruction
  // in flight always runs to completion. Backward next_state values are
  // followed as given; there is no loop guard.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state     <= FETCH;
      I             <= '0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else if (halted) begin
      if (!halt_req) begin
        halted <= 1'b0;
      end
    end else if (cur_state == FETCH) begin
      if (halt_req) begin
        halted <= 1'b1;
      end else if (imem_ready) begin
        I         <= I_in;
        cur_state <= EX1;
      end
    end else begin
      cur_state <= seq_state_t'(next_sel);
      if (retire) begin
        retired_count <= retired_count + CNTW'(1);
      end
    end
  end

  // Datapath control and fetch request. Held quiet during reset and while
  // halted. During execute steps the decoder output passes straight through.
  always_comb begin
    cw_out   = '0;
    imem_req = 1'b0;
    if (reset && !halted) begin
      if (cur_state == FETCH) begin
        imem_req = 1'b1;
        if (imem_ready) begin
          cw_out = fetch_cw;
        end
      end else begin
        cw_out = cw_decoded;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Self-checking bench for control_sequencer. It contains two instances that
// share every input. The main instance uses the default 16-bit counter. The
// second instance uses an 8-bit counter, so counter wrap can be reached in a
// few hundred cycles.
//
// Timing: inputs change on the falling edge. Outputs are sampled 1 time unit
// later, which shows the combinational outputs for the current cycle before
// the next rising edge.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  localparam int IW   = 32;
  localparam int CW   = 33;
  localparam int CNTW = 16;

  logic            clock;
  logic            reset;
  logic [IW-1:0]   I_in;
  logic            imem_ready;
  logic [CW-1:0]   cw_decoded;
  logic            halt_req;

  logic [IW-1:0]   I;
  logic [1:0]      state;
  logic [CW-1:0]   cw_out;
  logic            imem_req;
  logic            halted;
  logic [CNTW-1:0] retired_count;

  logic [IW-1:0]   I_s;
  logic [1:0]      state_s;
  logic [CW-1:0]   cw_out_s;
  logic            imem_req_s;
  logic            halted_s;
  logic [7:0]      retired_count_s;

  int assert_count;
  int fail_count;

  // Reference model: the phase number (0 = fetch, 1..3 = execute step), the
  // halt flag, the latched instruction, and an unbounded retire total that
  // is reduced modulo the counter width only at comparison time.
  int          m_phase;
  bit          m_halted;
  logic [31:0] m_I;
  int unsigned m_retired;

  control_sequencer #(.IW(IW), .CW(CW), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset), .I_in(I_in), .imem_ready(imem_ready),
    .cw_decoded(cw_decoded), .halt_req(halt_req), .I(I), .state(state),
    .cw_out(cw_out), .imem_req(imem_req), .halted(halted),
    .retired_count(retired_count)
  );

  control_sequencer #(.IW(IW), .CW(CW), .CNTW(8)) dut_small (
    .clock(clock), .reset(reset), .I_in(I_in), .imem_ready(imem_ready),
    .cw_decoded(cw_decoded), .halt_req(halt_req), .I(I_s), .state(state_s),
    .cw_out(cw_out_s), .imem_req(imem_req_s), .halted(halted_s),
    .retired_count(retired_count_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        halt;
    logic [31:0] iin;
    logic [32:0] cwd;
    logic [1:0]  e_state;
    logic        e_req;
    logic [32:0] e_cw;
    logic        e_halted;
    logic [15:0] e_count;
    logic [31:0] e_I;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic rst, input logic ready,
                                 input logic halt, input logic [31:0] iin,
                                 input logic [32:0] cwd, input logic [1:0] e_state,
                                 input logic e_req, input logic [32:0] e_cw,
                                 input logic e_halted, input logic [15:0] e_count,
                                 input logic [31:0] e_I);
    vec_t v;
    v.rst = rst; v.ready = ready; v.halt = halt; v.iin = iin; v.cwd = cwd;
    v.e_state = e_state; v.e_req = e_req; v.e_cw = e_cw;
    v.e_halted = e_halted; v.e_count = e_count; v.e_I = e_I;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic rst, input logic ready,
                               input logic halt, input logic [31:0] iin,
                               input logic [32:0] cwd);
    @(negedge clock);
    reset      = rst;
    imem_ready = ready;
    halt_req   = halt;
    I_in       = iin;
    cw_decoded = cwd;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_phase   = 0;
    m_halted  = 1'b0;
    m_I       = '0;
    m_retired = 0;
  endtask

  // Apply the rules for one rising edge to the reference model.
  task automatic modelAdvance(input logic ready, input logic halt,
                              input logic [31:0] iin, input logic [32:0] cwd);
    if (m_halted) begin
      m_halted = halt;
    end else if (m_phase == 0) begin
      if (halt) m_halted = 1'b1;
      else if (ready) begin
        m_I     = iin;
        m_phase = 1;
      end
    end else begin
      m_phase = int'(cwd[1:0]);
      if (m_phase == 0) m_retired = m_retired + 1;
    end
  endtask

  // One model-checked cycle: drive inputs, compare every output against
  // the model's view of this cycle, then step the model across the edge.
  task automatic runCycle(input logic rst, input logic ready, input logic halt,
                          input logic [31:0] iin, input logic [32:0] cwd);
    logic [32:0] e_cw;
    logic        e_req;
    applyStimulus(rst, ready, halt, iin, cwd);
    if (!rst) modelReset();
    e_cw  = '0;
    e_req = 1'b0;
    if (rst && !m_halted) begin
      if (m_phase == 0) begin
        e_req = 1'b1;
        e_cw  = ready ? 33'h10 : 33'h0;
      end else begin
        e_cw = cwd;
      end
    end
    checkOutput("state",    64'(state),    64'(m_phase));
    checkOutput("cw_out",   64'(cw_out),   64'(e_cw));
    checkOutput("imem_req", 64'(imem_req), 64'(e_req));
    checkOutput("halted",   64'(halted),   64'(m_halted));
    checkOutput("I",        64'(I),        64'(m_I));
    checkOutput("count16",  64'(retired_count),   64'(m_retired % 65536));
    checkOutput("count8",   64'(retired_count_s), 64'(m_retired % 256));
    if (rst) modelAdvance(ready, halt, iin, cwd);
  endtask

  initial begin
    logic [32:0] rcwd;
    assert_count = 0;
    fail_count   = 0;
    reset        = 1'b0;
    imem_ready   = 1'b0;
    halt_req     = 1'b0;
    I_in         = '0;
    cw_decoded   = '0;
    modelReset();

    // ---- table: reset, memory wait, single-step, 3-cycle, halt ----
    //      rst rdy hlt  iin           cwd            | st req cw             hlt cnt I
    addVec(0, 0, 0, 32'h0,        33'h0,          2'd0, 0, 33'h0,          0, 16'd0, 32'h0);
    addVec(1, 0, 0, 32'hDEADBEEF, 33'h0,          2'd0, 1, 33'h0,          0, 16'd0, 32'h0);
    addVec(1, 0, 0, 32'hDEADBEEF, 33'h1_0000_0001,2'd0, 1, 33'h0,          0, 16'd0, 32'h0);
    addVec(1, 0, 0, 32'hCAFEF00D, 33'h0,          2'd0, 1, 33'h0,          0, 16'd0, 32'h0);
    addVec(1, 0, 0, 32'hCAFEF00D, 33'h0,          2'd0, 1, 33'h0,          0, 16'd0, 32'h0);
    addVec(1, 1, 0, 32'hF2800041, 33'h0,          2'd0, 1, 33'h10,         0, 16'd0, 32'h0);
    addVec(1, 0, 0, 32'h0,        33'h0_8000_0200,2'd1, 0, 33'h0_8000_0200,0, 16'd0, 32'hF2800041);
    addVec(1, 0, 0, 32'h0,        33'h0,          2'd0, 1, 33'h0,          0, 16'd1, 32'hF2800041);
    addVec(1, 1, 0, 32'h12345678, 33'h0,          2'd0, 1, 33'h10,         0, 16'd1, 32'hF2800041);
    addVec(1, 0, 0, 32'h0,        33'h1_0000_0002,2'd1, 0, 33'h1_0000_0002,0, 16'd1, 32'h12345678);
    addVec(1, 0, 0, 32'h0,        33'h0_FFFF_FFF3,2'd2, 0, 33'h0_FFFF_FFF3,0, 16'd1, 32'h12345678);
    addVec(1, 0, 0, 32'h0,        33'h1_5555_5554,2'd3, 0, 33'h1_5555_5554,0, 16'd1, 32'h12345678);
    addVec(1, 0, 0, 32'h0,        33'h0,          2'd0, 1, 33'h0,          0, 16'd2, 32'h12345678);
    addVec(1, 1, 0, 32'hAAAA5555, 33'h0,          2'd0, 1, 33'h10,         0, 16'd2, 32'h12345678);
    addVec(1, 0, 0, 32'h0,        33'h0_0000_0402,2'd1, 0, 33'h0_0000_0402,0, 16'd2, 32'hAAAA5555);
    addVec(1, 0, 1, 32'h0,        33'h0_0000_0800,2'd2, 0, 33'h0_0000_0800,0, 16'd2, 32'hAAAA5555);
    addVec(1, 0, 1, 32'h0,        33'h0,          2'd0, 1, 33'h0,          0, 16'd3, 32'hAAAA5555);
    addVec(1, 1, 1, 32'h11111111, 33'h1_FFFF_FFFF,2'd0, 0, 33'h0,          1, 16'd3, 32'hAAAA5555);
    addVec(1, 1, 0, 32'h22222222, 33'h0,          2'd0, 0, 33'h0,          1, 16'd3, 32'hAAAA5555);
    addVec(1, 0, 0, 32'h0,        33'h0,          2'd0, 1, 33'h0,          0, 16'd3, 32'hAAAA5555);

    $display("[TB] directed vector table, %0d entries", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ready, vecs[i].halt, vecs[i].iin, vecs[i].cwd);
      checkOutput($sformatf("v%0d.state", i),    64'(state),    64'(vecs[i].e_state));
      checkOutput($sformatf("v%0d.imem_req", i), 64'(imem_req), 64'(vecs[i].e_req));
      checkOutput($sformatf("v%0d.cw_out", i),   64'(cw_out),   64'(vecs[i].e_cw));
      checkOutput($sformatf("v%0d.halted", i),   64'(halted),   64'(vecs[i].e_halted));
      checkOutput($sformatf("v%0d.count", i),    64'(retired_count), 64'(vecs[i].e_count));
      checkOutput($sformatf("v%0d.count8", i),   64'(retired_count_s), 64'(vecs[i].e_count[7:0]));
      checkOutput($sformatf("v%0d.I", i),        64'(I),        64'(vecs[i].e_I));
    end

    // ---- backward next_state: EX1 -> EX3 -> EX1 -> EX2 -> retire ----
    runCycle(0, 0, 0, 32'h0, 33'h0);
    runCycle(1, 1, 0, 32'h0BAD0BAD, 33'h0);
    runCycle(1, 0, 0, 32'h0, 33'h0_0000_0103);
    runCycle(1, 0, 0, 32'h0, 33'h1_0000_0001);
    runCycle(1, 0, 0, 32'h0, 33'h0_0F00_0002);
    runCycle(1, 0, 0, 32'h0, 33'h0_0000_0000);
    runCycle(1, 0, 0, 32'h0, 33'h0);

    // ---- reset asserted mid-EX2 takes effect before the next edge ----
    runCycle(1, 1, 0, 32'h76543210, 33'h0);
    runCycle(1, 0, 0, 32'h0, 33'h0_0000_0002);
    applyStimulus(1, 0, 0, 32'h0, 33'h1_FFFF_FFF3);
    checkOutput("ex2.state", 64'(state), 64'd2);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst.state",    64'(state),    64'd0);
    checkOutput("rst.I",        64'(I),        64'd0);
    checkOutput("rst.halted",   64'(halted),   64'd0);
    checkOutput("rst.count",    64'(retired_count), 64'd0);
    checkOutput("rst.cw_out",   64'(cw_out),   64'd0);
    checkOutput("rst.imem_req", 64'(imem_req), 64'd0);
    modelReset();
    runCycle(0, 1, 0, 32'h0, 33'h0);
    runCycle(1, 0, 0, 32'h0, 33'h0);

    // ---- counter wrap on the 8-bit instance ----
    runCycle(0, 0, 0, 32'h0, 33'h0);
    for (int n = 0; n < 255; n++) begin
      runCycle(1, 1, 0, $urandom, 33'h0);
      rcwd = {1'b0, $urandom};
      runCycle(1, 0, 0, 32'h0, {rcwd[32:2], 2'b00});
    end
    @(negedge clock); #1;
    checkOutput("pre_wrap.count8",  64'(retired_count_s), 64'hFF);
    checkOutput("pre_wrap.count16", 64'(retired_count),   64'd255);
    runCycle(1, 1, 0, 32'h5A5A5A5A, 33'h0);
    runCycle(1, 0, 0, 32'h0, 33'h1_0000_0000);
    @(negedge clock); #1;
    checkOutput("wrap.count8",  64'(retired_count_s), 64'h00);
    checkOutput("wrap.count16", 64'(retired_count),   64'd256);

    // ---- randomized run against the reference model ----
    runCycle(0, 0, 0, 32'h0, 33'h0);
    for (int n = 0; n < 3000; n++) begin
      logic r_rst, r_ready, r_halt;
      r_rst   = ($urandom_range(0, 299) != 0);
      r_ready = $urandom_range(0, 1) == 1;
      r_halt  = ($urandom_range(0, 9) == 0);
      rcwd    = {$urandom_range(0, 1) == 1, $urandom};
      runCycle(r_rst, r_ready, r_halt, $urandom, rcwd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
